// File: rtl/gsim_param.sv
// Gauss-Seidel solver for a 7-band Toeplitz system of N unknowns; 4 cycles per update, sweeps until converged or the limit.
// Latency 4*N*S cycles after the last b beat; b input has no back-pressure, results wait on out_ready.
module gsim_param #(
    parameter int N    = 16,
    parameter int B_W  = 16,
    parameter int FRAC = 16,
    parameter int X_W  = 32
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           in_en,
    input  logic [B_W-1:0] b_in,
    input  logic [7:0]     iter_lim,
    input  logic [X_W-1:0] conv_thr,
    output logic           busy,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [X_W-1:0] x_out,
    output logic           out_last,
    output logic [7:0]     sweeps_done
);

    localparam int IW    = $clog2(N);
    localparam int ACC_W = X_W + 6;
    localparam logic [IW-1:0]           LAST = IW'(N - 1);
    localparam logic signed [X_W-1:0]   ONE  = X_W'(1) << FRAC;
    localparam logic signed [ACC_W-1:0] C13  = ACC_W'(13);
    localparam logic signed [ACC_W-1:0] C6   = ACC_W'(6);
    localparam logic signed [ACC_W-1:0] DIV  = ACC_W'(20);

    typedef enum logic [1:0] {RECV, CALC, SEND} state_t;
    state_t state, state_nxt;

    logic signed [B_W-1:0]   b_mem [N];
    logic signed [X_W-1:0]   x_mem [N];
    logic [IW-1:0]           idx;
    logic [IW-1:0]           idx_inc;
    logic [1:0]              phase;
    logic [7:0]              lim;
    logic [X_W-1:0]          thr;
    logic signed [ACC_W-1:0] pair [3];
    logic signed [ACC_W-1:0] acc_c, acc_q;
    logic signed [X_W-1:0]   x_new_q;
    logic [X_W:0]            diff, delta_c, delta_q, sweep_max, max_c;
    logic                    sweep_end, solved, accept;

    assign idx_inc   = idx + 1'b1;
    assign accept    = out_valid & out_ready;
    assign sweep_end = (state == CALC) && (phase == 2'd3) && (idx == LAST);
    assign max_c     = (delta_q > sweep_max) ? delta_q : sweep_max;
    assign solved    = (max_c <= {1'b0, thr}) || ((sweeps_done + 8'd1) == lim);

    // Out-of-range neighbours contribute zero; lower indices already hold this sweep's values.
    always_comb begin
        for (int d = 0; d < 3; d++) begin
            pair[d] = '0;
            if (int'(idx) - d - 1 >= 0)
                pair[d] = pair[d] + ACC_W'(x_mem[idx - IW'(d + 1)]);
            if (int'(idx) + d + 1 < N)
                pair[d] = pair[d] + ACC_W'(x_mem[idx + IW'(d + 1)]);
        end
        acc_c = (ACC_W'(b_mem[idx]) <<< FRAC) + C13 * pair[0] - C6 * pair[1] + pair[2];
    end

    always_comb begin
        diff    = {x_new_q[X_W-1], x_new_q} - {x_mem[idx][X_W-1], x_mem[idx]};
        delta_c = diff[X_W] ? (~diff + 1'b1) : diff;
    end

    always_ff @(posedge clk) begin
        if (reset) state <= RECV;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            RECV:    if (in_en && idx == LAST) state_nxt = CALC;
            CALC:    if (sweep_end && solved) state_nxt = SEND;
            SEND:    if (accept && out_last) state_nxt = RECV;
            default: state_nxt = RECV;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            idx         <= '0;
            phase       <= '0;
            busy        <= 1'b0;
            out_valid   <= 1'b0;
            out_last    <= 1'b0;
            x_out       <= '0;
            sweeps_done <= '0;
            sweep_max   <= '0;
        end else begin
            case (state)
                RECV: if (in_en) begin
                    b_mem[idx] <= b_in;
                    busy       <= 1'b1;
                    if (idx == '0) begin
                        lim         <= (iter_lim == 8'd0) ? 8'd1 : iter_lim;
                        thr         <= conv_thr;
                        sweeps_done <= '0;
                    end
                    if (idx == LAST) begin
                        idx       <= '0;
                        phase     <= '0;
                        sweep_max <= '0;
                        for (int k = 0; k < N; k++) x_mem[k] <= ONE;
                    end else begin
                        idx <= idx_inc;
                    end
                end
                CALC: begin
                    phase <= phase + 2'd1;
                    case (phase)
                        2'd0:    acc_q   <= acc_c;
                        2'd1:    x_new_q <= X_W'(acc_q / DIV);
                        2'd2:    delta_q <= delta_c;
                        default: begin
                            x_mem[idx] <= x_new_q;
                            if (idx == LAST) begin
                                idx         <= '0;
                                sweeps_done <= sweeps_done + 8'd1;
                                sweep_max   <= '0;
                                if (solved) begin
                                    out_valid <= 1'b1;
                                    out_last  <= 1'b0;
                                    x_out     <= x_mem[0];
                                end
                            end else begin
                                idx       <= idx_inc;
                                sweep_max <= max_c;
                            end
                        end
                    endcase
                end
                SEND: if (accept) begin
                    if (out_last) begin
                        out_valid <= 1'b0;
                        out_last  <= 1'b0;
                        busy      <= 1'b0;
                        idx       <= '0;
                    end else begin
                        idx      <= idx_inc;
                        x_out    <= x_mem[idx_inc];
                        out_last <= (idx_inc == LAST);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
